// File: rtl/code_entry.sv
// code_entry: synchronises/debounces lock buttons and sequences digit entry into
// store/input/compare/reset pulses for the code checker.
module code_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PW_LEN = 4,
  parameter int DIGIT_W = 2
) (
  input  logic               clk,
  input  logic               system_reset,
  input  logic               store_btn_n,
  input  logic               input_btn_n,
  input  logic               submit_btn_n,
  input  logic [DIGIT_W-1:0] digit_sw,
  output logic               store_value,
  output logic               input_value,
  output logic [DIGIT_W-1:0] bits,
  output logic               compare,
  output logic               input_reset,
  output logic               entry_error,
  output logic               pw_set,
  output logic [2:0]         digit_count
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DLIM = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] PW = 3'(PW_LEN);
  localparam logic [1:0] IDLE = 2'd0, STORE = 2'd1, INPUT = 2'd2;
  // button index: 0 store, 1 input, 2 submit
  logic [2:0] btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, db_q, db_d, press_q, press_d;
  logic [CW-1:0] dcnt_q [3];
  logic [CW-1:0] dcnt_d [3];
  logic [DIGIT_W-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d, bits_q, bits_d;
  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic pw_set_q, pw_set_d, sv_q, sv_d, iv_q, iv_d, cmp_q, cmp_d, ir_q, ir_d, err_q, err_d;
  logic st_ev, in_ev, sub_ev;
  always_comb begin
    btn_s1_d = {submit_btn_n, input_btn_n, store_btn_n};
    btn_s2_d = btn_s1_q;
    sw_s1_d = digit_sw;
    sw_s2_d = sw_s1_q;
    db_d = db_q;
    press_d = '0;
    for (int i = 0; i < 3; i++) begin
      dcnt_d[i] = '0;
      if (btn_s2_q[i] != db_q[i]) begin
        if (dcnt_q[i] == DLIM) begin
          db_d[i] = btn_s2_q[i];
          press_d[i] = ~btn_s2_q[i];
        end else dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
    end
  end
  assign sub_ev = press_q[2];
  assign st_ev = press_q[0] & ~press_q[2];
  assign in_ev = press_q[1] & ~press_q[2] & ~press_q[0];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pw_set_d = pw_set_q;
    sv_d = 1'b0;
    iv_d = 1'b0;
    cmp_d = 1'b0;
    err_d = 1'b0;
    ir_d = cmp_q;  // attempt register clears the cycle after compare
    case (state_q)
      IDLE: begin
        if (sub_ev) begin
          err_d = 1'b1;
          ir_d = 1'b1;
        end else if (st_ev) begin
          sv_d = 1'b1;
          pw_set_d = pw_set_q | (PW == 3'd1);
          cnt_d = (PW == 3'd1) ? 3'd0 : 3'd1;
          state_d = (PW == 3'd1) ? IDLE : STORE;
        end else if (in_ev) begin
          iv_d = 1'b1;
          cnt_d = 3'd1;
          state_d = INPUT;
        end
      end
      STORE: begin
        if (st_ev) begin
          sv_d = 1'b1;
          pw_set_d = pw_set_q | (cnt_q + 3'd1 == PW);
          cnt_d = (cnt_q + 3'd1 == PW) ? 3'd0 : cnt_q + 3'd1;
          state_d = (cnt_q + 3'd1 == PW) ? IDLE : STORE;
        end
      end
      INPUT: begin
        if (sub_ev) begin
          cmp_d = (cnt_q == PW);
          err_d = (cnt_q != PW);
          ir_d = (cnt_q != PW);
          cnt_d = 3'd0;
          state_d = IDLE;
        end else if (in_ev && cnt_q < PW) begin
          iv_d = 1'b1;
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    bits_d = (sv_d | iv_d) ? sw_s2_q : bits_q;
  end
  always_ff @(posedge clk) begin
    if (system_reset) begin
      btn_s1_q <= '1;
      btn_s2_q <= '1;
      sw_s1_q <= '1;
      sw_s2_q <= '1;
      db_q <= '1;
      press_q <= '0;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
      state_q <= IDLE;
      cnt_q <= '0;
      pw_set_q <= 1'b0;
      sv_q <= 1'b0;
      iv_q <= 1'b0;
      cmp_q <= 1'b0;
      ir_q <= 1'b0;
      err_q <= 1'b0;
      bits_q <= '0;
    end else begin
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
      db_q <= db_d;
      press_q <= press_d;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= dcnt_d[i];
      state_q <= state_d;
      cnt_q <= cnt_d;
      pw_set_q <= pw_set_d;
      sv_q <= sv_d;
      iv_q <= iv_d;
      cmp_q <= cmp_d;
      ir_q <= ir_d;
      err_q <= err_d;
      bits_q <= bits_d;
    end
  end
  assign store_value = sv_q;
  assign input_value = iv_q;
  assign compare = cmp_q;
  assign input_reset = ir_q;
  assign entry_error = err_q;
  assign bits = bits_q;
  assign pw_set = pw_set_q;
  assign digit_count = cnt_q;
endmodule
